jtframe_db15_resp: RTL and testbench



---
 rtl/jtframe_db15_pkg.sv | 28 ++
 rtl/jtframe_db15_resp_if.sv | 9 +
 rtl/jtframe_sync.sv | 25 ++
 rtl/jtframe_db15_resp.sv | 100 ++++++++++
 tb/tb_jtframe_db15_resp.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_db15_pkg.sv
// Shared constants and helpers for the DB15 joystick serial link.
// Button bit positions match the joy_db15 reader; db15_frame gives the wire-level frame.
package jtframe_db15_pkg;

  localparam int unsigned W_DEF = 16;
  localparam int unsigned CNT_W = 6;

  localparam int unsigned BTN_RIGHT = 0;
  localparam int unsigned BTN_LEFT  = 1;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_UP    = 3;
  localparam int unsigned BTN_B1    = 4;
  localparam int unsigned BTN_B2    = 5;
  localparam int unsigned BTN_B3    = 6;
  localparam int unsigned BTN_B4    = 7;
  localparam int unsigned BTN_B5    = 8;
  localparam int unsigned BTN_B6    = 9;
  localparam int unsigned BTN_START = 10;
  localparam int unsigned BTN_COIN  = 11;
  localparam int unsigned BTN_MODE  = 12;

  // Wire-level frame, MSB shifted first: P1 high..low then P2, active-low levels.
  function automatic logic [2*W_DEF-1:0] db15_frame(input logic [W_DEF-1:0] j1,
                                                    input logic [W_DEF-1:0] j2);
    return ~{j1, j2};
  endfunction

endpackage

// File: rtl/jtframe_db15_resp_if.sv
// DB15 serial link pins: reader (master) drives the strobes, responder (slave) drives data.
interface jtframe_db15_resp_if;
  logic JOY_CLK;
  logic JOY_LOAD;
  logic JOY_DATA;

  modport master (output JOY_CLK, output JOY_LOAD, input  JOY_DATA);
  modport slave  (input  JOY_CLK, input  JOY_LOAD, output JOY_DATA);
endinterface

// File: rtl/jtframe_sync.sv
// Multi-stage synchronizer for an asynchronous strobe; resets to 1 so idle-high
// strobes produce no spurious edge after reset.
module jtframe_sync #(
  parameter int unsigned SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [SYNC-1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= sync_d;
  end

  assign dout = sync_q[SYNC-1];

endmodule

// File: rtl/jtframe_db15_resp.sv
// DB15 splitter emulation: parallel-in/serial-out chain driven by the reader's
// JOY_LOAD/JOY_CLK strobes, with frame pulse, shift counter and overflow flag.
module jtframe_db15_resp
  import jtframe_db15_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned SYNC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [W-1:0]        joystick1,
  input  logic [W-1:0]        joystick2,
  jtframe_db15_resp_if.slave  db15,
  output logic                frame,
  output logic [CNT_W-1:0]    bit_cnt,
  output logic                ovf
);

  localparam int unsigned         FL        = 2 * W;
  localparam logic [CNT_W-1:0]    FRAME_LEN = CNT_W'(FL);

  logic clk_s, load_s;
  logic clk_dly_q, clk_dly_d;
  logic load_dly_q, load_dly_d;
  logic clk_rise, load_rise;

  logic [FL-1:0]    sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             frame_q, frame_d;
  logic [FL-1:0]    load_val;

  jtframe_sync #(.SYNC(SYNC)) u_sync_clk (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (db15.JOY_CLK),
    .dout  (clk_s)
  );

  jtframe_sync #(.SYNC(SYNC)) u_sync_load (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (db15.JOY_LOAD),
    .dout  (load_s)
  );

  // Default width uses the shared frame helper so RTL and reader agree on bit order.
  if (W == W_DEF) begin : g_pkg_frame
    assign load_val = db15_frame(joystick1, joystick2);
  end else begin : g_gen_frame
    assign load_val = ~{joystick1, joystick2};
  end

  assign clk_rise  = clk_s  & ~clk_dly_q;
  assign load_rise = load_s & ~load_dly_q;

  always_comb begin
    clk_dly_d  = clk_s;
    load_dly_d = load_s;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    frame_d    = load_rise;

    // Transparent load dominates; a shift coinciding with the load release is dropped.
    if (!load_s) begin
      sr_d  = load_val;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (clk_rise && !load_rise) begin
      sr_d = {sr_q[FL-2:0], 1'b1};
      if (cnt_q == FRAME_LEN) ovf_d = 1'b1;
      else                    cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_dly_q  <= 1'b1;
      load_dly_q <= 1'b1;
      sr_q       <= '1;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      clk_dly_q  <= clk_dly_d;
      load_dly_q <= load_dly_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      frame_q    <= frame_d;
    end
  end

  assign db15.JOY_DATA = sr_q[FL-1];
  assign frame         = frame_q;
  assign bit_cnt       = cnt_q;
  assign ovf           = ovf_q;

endmodule

// File: tb/tb_jtframe_db15_resp.sv
// Directed bench for jtframe_db15_resp acting as the joy_db15 reader.
module tb_jtframe_db15_resp;
  import jtframe_db15_pkg::*;

  localparam int unsigned HOLD = 6;

  logic        clk;
  logic        rst_n;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame;
  logic [5:0]  bit_cnt;
  logic        ovf;

  int checks;
  int errors;
  int frame_cnt;

  jtframe_db15_resp_if bus ();

  jtframe_db15_resp u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .db15      (bus),
    .frame     (frame),
    .bit_cnt   (bit_cnt),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (frame === 1'b1) frame_cnt <= frame_cnt + 1;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load();
    bus.JOY_LOAD = 1'b0;
    wait_cyc(HOLD);
    bus.JOY_LOAD = 1'b1;
    wait_cyc(HOLD);
  endtask

  task automatic shift_one();
    bus.JOY_CLK = 1'b1;
    wait_cyc(HOLD);
    bus.JOY_CLK = 1'b0;
    wait_cyc(HOLD);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cyc(4);
    checks++;
    if (frame_cnt !== 0) begin errors++; $display("FAIL reset_frame_in_rst got %0d want 0", frame_cnt); end
    rst_n = 1'b1;
    wait_cyc(10);
    checks++;
    if (bus.JOY_DATA !== 1'b1) begin errors++; $display("FAIL reset_data got %b want 1", bus.JOY_DATA); end
    checks++;
    if (bit_cnt !== 6'd0) begin errors++; $display("FAIL reset_bit_cnt got %0d want 0", bit_cnt); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
    checks++;
    if (frame_cnt !== 0) begin errors++; $display("FAIL reset_frame_idle got %0d want 0", frame_cnt); end
  endtask

  task automatic test_frame();
    logic [31:0] exp;
    int f0;
    exp = 32'hFFFE_7FFF;
    joystick1 = 16'h0001;
    joystick2 = 16'h8000;
    f0 = frame_cnt;
    do_load();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (bus.JOY_DATA !== exp[31-i]) begin
        errors++; $display("FAIL frame_bit%0d got %b want %b", i, bus.JOY_DATA, exp[31-i]);
      end
      shift_one();
    end
    checks++;
    if (bit_cnt !== 6'd32) begin errors++; $display("FAIL frame_bit_cnt got %0d want 32", bit_cnt); end
    checks++;
    if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL frame_pulses got %0d want 1", frame_cnt - f0); end
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL frame_ovf got %b want 0", ovf); end
  endtask

  task automatic test_overflow();
    repeat (3) shift_one();
    checks++;
    if (bus.JOY_DATA !== 1'b1) begin errors++; $display("FAIL ovf_data got %b want 1", bus.JOY_DATA); end
    checks++;
    if (bit_cnt !== 6'd32) begin errors++; $display("FAIL ovf_bit_cnt got %0d want 32", bit_cnt); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
    do_load();
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
    checks++;
    if (bit_cnt !== 6'd0) begin errors++; $display("FAIL ovf_load_cnt got %0d want 0", bit_cnt); end
  endtask

  task automatic test_midframe_change();
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    do_load();
    for (int i = 0; i < 4; i++) shift_one();
    joystick1 = 16'hFFFF;
    for (int i = 4; i < 16; i++) begin
      checks++;
      if (bus.JOY_DATA !== 1'b1) begin errors++; $display("FAIL mid_old_bit%0d got %b want 1", i, bus.JOY_DATA); end
      shift_one();
    end
    do_load();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (bus.JOY_DATA !== 1'b0) begin errors++; $display("FAIL mid_new_bit%0d got %b want 0", i, bus.JOY_DATA); end
      shift_one();
    end
  endtask

  task automatic test_collision();
    joystick1 = 16'h0000;
    joystick2 = 16'h0000;
    do_load();
    shift_one();
    shift_one();
    joystick1 = 16'h8000;
    bus.JOY_CLK  = 1'b1;
    bus.JOY_LOAD = 1'b0;
    wait_cyc(HOLD);
    checks++;
    if (bit_cnt !== 6'd0) begin errors++; $display("FAIL coll_load_cnt got %0d want 0", bit_cnt); end
    checks++;
    if (bus.JOY_DATA !== 1'b0) begin errors++; $display("FAIL coll_load_data got %b want 0", bus.JOY_DATA); end
    bus.JOY_LOAD = 1'b1;
    wait_cyc(HOLD);
    bus.JOY_CLK = 1'b0;
    wait_cyc(HOLD);
    checks++;
    if (bus.JOY_DATA !== 1'b0) begin errors++; $display("FAIL coll_hold_data got %b want 0", bus.JOY_DATA); end
    // Load release and shift edge in the same cycle: frame pulses, no shift.
    bus.JOY_LOAD = 1'b0;
    wait_cyc(HOLD);
    joystick1 = 16'h0000;
    bus.JOY_LOAD = 1'b1;
    bus.JOY_CLK  = 1'b1;
    wait_cyc(HOLD);
    checks++;
    if (bit_cnt !== 6'd0) begin errors++; $display("FAIL coll_rise_cnt got %0d want 0", bit_cnt); end
    checks++;
    if (bus.JOY_DATA !== 1'b1) begin errors++; $display("FAIL coll_rise_data got %b want 1", bus.JOY_DATA); end
    bus.JOY_CLK = 1'b0;
    wait_cyc(HOLD);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] exp;
    int f0;
    joystick1 = 16'hA5C3;
    joystick2 = 16'h1234;
    do_load();
    for (int i = 0; i < 10; i++) shift_one();
    f0 = frame_cnt;
    rst_n = 1'b0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(HOLD);
    checks++;
    if (bus.JOY_DATA !== 1'b1) begin errors++; $display("FAIL rstmid_data got %b want 1", bus.JOY_DATA); end
    checks++;
    if (bit_cnt !== 6'd0) begin errors++; $display("FAIL rstmid_cnt got %0d want 0", bit_cnt); end
    checks++;
    if (frame_cnt !== f0) begin errors++; $display("FAIL rstmid_frame got %0d want %0d", frame_cnt, f0); end
    exp = db15_frame(joystick1, joystick2);
    do_load();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (bus.JOY_DATA !== exp[31-i]) begin
        errors++; $display("FAIL rstmid_bit%0d got %b want %b", i, bus.JOY_DATA, exp[31-i]);
      end
      shift_one();
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    frame_cnt    = 0;
    rst_n        = 1'b0;
    joystick1    = 16'h0000;
    joystick2    = 16'h0000;
    bus.JOY_CLK  = 1'b0;
    bus.JOY_LOAD = 1'b1;
    test_reset();
    test_frame();
    test_overflow();
    test_midframe_change();
    test_collision();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
